// File: rtl/uart_cmd_parser.sv
// UART command frame parser: SYNC, OP, ADDR_H, ADDR_L, LEN, payload and XOR checksum.
// Validated frames are held for the consumer and the payload is read through a side port.
`timescale 1ns/10ps
module uart_cmd_parser #(
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 86900,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [15:0] cmd_addr,
    output logic [7:0]  cmd_len,
    input  logic [7:0]  pl_idx,
    output logic [7:0]  pl_data,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYC);
    localparam logic [8:0]    MAX_LEN9   = 9'(MAX_LEN);

    localparam logic [2:0] S_SYNC    = 3'd0;
    localparam logic [2:0] S_OP      = 3'd1;
    localparam logic [2:0] S_ADDR_H  = 3'd2;
    localparam logic [2:0] S_ADDR_L  = 3'd3;
    localparam logic [2:0] S_LEN     = 3'd4;
    localparam logic [2:0] S_PAYLOAD = 3'd5;
    localparam logic [2:0] S_CHK     = 3'd6;
    localparam logic [2:0] S_HOLD    = 3'd7;

    localparam logic [1:0] E_TIMEOUT = 2'd1;
    localparam logic [1:0] E_LEN     = 2'd2;
    localparam logic [1:0] E_CHK     = 2'd3;

    logic [2:0]    state;
    logic          rx_prev;
    logic [7:0]    chk;
    logic [7:0]    idx;
    logic [TW-1:0] timer;
    logic [7:0]    pl_buf [0:MAX_LEN-1];

    logic byte_ev;
    logic active;
    logic timeout_hit;
    logic buf_we;

    // One event per byte: only the rising edge of rx_done counts, however long it stays high.
    assign byte_ev     = rx_done & ~rx_prev;
    assign active      = (state != S_SYNC) && (state != S_HOLD);
    assign timeout_hit = active && !byte_ev && (timer == TIMER_LAST);
    assign buf_we      = byte_ev && (state == S_PAYLOAD);

    assign pl_data = ({1'b0, pl_idx} < MAX_LEN9) ? pl_buf[pl_idx[IW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_SYNC;
            rx_prev   <= 1'b0;
            chk       <= 8'h00;
            idx       <= 8'h00;
            timer     <= '0;
            cmd_valid <= 1'b0;
            cmd_op    <= 8'h00;
            cmd_addr  <= 16'h0000;
            cmd_len   <= 8'h00;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            rx_prev <= rx_done;
            err     <= 1'b0;

            if (!active || byte_ev) begin
                timer <= '0;
            end else if (timer != TIMER_MAX) begin
                timer <= timer + 1'b1;
            end

            if (timeout_hit) begin
                err      <= 1'b1;
                err_code <= E_TIMEOUT;
                state    <= S_SYNC;
            end else if (state == S_HOLD) begin
                // Overrun and handshake are independent: both may happen in one cycle.
                if (byte_ev) begin
                    err      <= 1'b1;
                    err_code <= E_CHK;
                end
                if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    state     <= S_SYNC;
                end
            end else if (byte_ev) begin
                case (state)
                    S_SYNC: begin
                        if (rx_data == SYNC_BYTE) begin
                            chk   <= 8'h00;
                            state <= S_OP;
                        end
                    end
                    S_OP: begin
                        cmd_op <= rx_data;
                        chk    <= chk ^ rx_data;
                        state  <= S_ADDR_H;
                    end
                    S_ADDR_H: begin
                        cmd_addr[15:8] <= rx_data;
                        chk            <= chk ^ rx_data;
                        state          <= S_ADDR_L;
                    end
                    S_ADDR_L: begin
                        cmd_addr[7:0] <= rx_data;
                        chk           <= chk ^ rx_data;
                        state         <= S_LEN;
                    end
                    S_LEN: begin
                        if ({1'b0, rx_data} > MAX_LEN9) begin
                            err      <= 1'b1;
                            err_code <= E_LEN;
                            state    <= S_SYNC;
                        end else begin
                            cmd_len <= rx_data;
                            chk     <= chk ^ rx_data;
                            idx     <= 8'h00;
                            state   <= (rx_data == 8'h00) ? S_CHK : S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        chk <= chk ^ rx_data;
                        idx <= idx + 8'd1;
                        if (idx == 8'(cmd_len - 8'd1)) begin
                            state <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        if (rx_data == chk) begin
                            cmd_valid <= 1'b1;
                            state     <= S_HOLD;
                        end else begin
                            err      <= 1'b1;
                            err_code <= E_CHK;
                            state    <= S_SYNC;
                        end
                    end
                    default: state <= S_SYNC;
                endcase
            end
        end
    end

    // Payload storage is never cleared; bytes beyond the current length stay stale.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            pl_buf[idx[IW-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: scoreboarded frames and error codes.
`timescale 1ns/10ps
module tb_uart_cmd_parser;

    localparam int MAX_LEN = 16;
    localparam int TO_CYC  = 20000;

    typedef struct packed {
        logic [7:0]   op;
        logic [15:0]  addr;
        logic [7:0]   len;
        logic [127:0] pl;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [7:0]  pl_idx = 8'h00;
    logic [7:0]  pl_data;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    frame_t     exp_q [$];
    logic [1:0] exp_err [$];
    logic       err_prev = 1'b0;

    uart_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO_CYC), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .pl_idx(pl_idx), .pl_data(pl_data),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Error scoreboard: every err pulse is matched against the next expected code.
    always @(negedge clk) begin
        if (err) begin
            checks++;
            if (err_prev) begin
                errors++;
                $display("[TB] FAIL err_pulse_width: err high for 2+ cycles, required 1");
            end else if (exp_err.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_err: got code %0d, required no error", err_code);
            end else begin
                logic [1:0] code;
                code = exp_err.pop_front();
                if (err_code !== code) begin
                    errors++;
                    $display("[TB] FAIL err_code: got %0d, required %0d", err_code, code);
                end
            end
        end
        err_prev = err;
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] len,
                              input logic [127:0] pl, input bit bad_chk, input int hold);
        frame_t     f;
        logic [7:0] chk;
        logic [7:0] b;
        f      = '0;
        f.op   = op;
        f.addr = addr;
        f.len  = len;
        chk    = op ^ addr[15:8] ^ addr[7:0] ^ len;
        send_byte(8'hA5, hold);
        send_byte(op, hold);
        send_byte(addr[15:8], hold);
        send_byte(addr[7:0], hold);
        if (int'(len) > MAX_LEN) begin
            exp_err.push_back(2'd2);
            send_byte(len, hold);
        end else begin
            send_byte(len, hold);
            for (int i = 0; i < int'(len); i++) begin
                b = pl[i*8 +: 8];
                f.pl[i*8 +: 8] = b;
                chk = chk ^ b;
                send_byte(b, hold);
            end
            if (bad_chk) exp_err.push_back(2'd3);
            else         exp_q.push_back(f);
            send_byte(bad_chk ? ~chk : chk, hold);
        end
    endtask

    // Observation only: waits for cmd_valid and snapshots the held frame.
    task automatic collect_frame(output bit ok, output frame_t f);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        f      = '0;
        f.op   = cmd_op;
        f.addr = cmd_addr;
        f.len  = cmd_len;
        for (int i = 0; i < MAX_LEN; i++) begin
            pl_idx = 8'(i);
            #0.2;
            if (i < int'(cmd_len)) f.pl[i*8 +: 8] = pl_data;
        end
        @(negedge clk);
    endtask

    task automatic release_frame();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_valid, err, err_code, cmd_op, cmd_addr, cmd_len} !== 37'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%b e=%b c=%0d op=%h a=%h l=%h, required all 0",
                     cmd_valid, err, err_code, cmd_op, cmd_addr, cmd_len);
        end
        rst = 1'b1;
        @(negedge clk);
        pl_idx = 8'd16;
        #0.2;
        checks++;
        if (pl_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL pl_out_of_range: got %h, required 00", pl_data);
        end
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        frame_t     exp_f, got;
        bit         ok;
        logic [7:0] bytes [7];
        logic [7:0] chk;
        bytes = '{8'hA5, 8'h10, 8'h12, 8'h34, 8'h02, 8'hAB, 8'hCD};
        chk   = 8'h10 ^ 8'h12 ^ 8'h34 ^ 8'h02 ^ 8'hAB ^ 8'hCD;
        exp_f = '0;
        exp_f.op = 8'h10; exp_f.addr = 16'h1234; exp_f.len = 8'h02;
        exp_f.pl[7:0] = 8'hAB; exp_f.pl[15:8] = 8'hCD;
        exp_q.push_back(exp_f);
        foreach (bytes[i]) send_byte(bytes[i], 1);
        rx_data = chk;
        rx_done = 1'b1;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL valid_early: got %b before CHK byte, required 0", cmd_valid);
        end
        @(negedge clk);
        rx_done = 1'b0;
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL valid_latency: got %b one clk after CHK, required 1", cmd_valid);
        end
        collect_frame(ok, got);
        exp_f = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp_f) begin
            errors++;
            $display("[TB] FAIL basic_frame: got ok=%b %h, required %h", ok, got, exp_f);
        end
        pl_idx = 8'd200;
        #0.2;
        checks++;
        if (pl_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL pl_idx_200: got %h, required 00", pl_data);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL valid_held: got %b while not ready, required 1", cmd_valid);
        end
        release_frame();
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL valid_drop: got %b after handshake, required 0", cmd_valid);
        end
    endtask

    task automatic test_len_zero();
        frame_t exp_f, got;
        bit     ok;
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        send_frame(8'h20, 16'h0000, 8'd0, '0, 1'b0, 1);
        collect_frame(ok, got);
        exp_f = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp_f) begin
            errors++;
            $display("[TB] FAIL len_zero_frame: got ok=%b %h, required %h", ok, got, exp_f);
        end
        release_frame();
    endtask

    task automatic test_bad_checksum();
        frame_t exp_f, got;
        bit     ok;
        send_frame(8'h10, 16'h1234, 8'd2, 128'hCDAB, 1'b1, 1);
        repeat (4) @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_chk_no_valid: got %b, required 0", cmd_valid);
        end
        send_frame(8'h33, 16'hBEEF, 8'd3, 128'h665544, 1'b0, 1);
        collect_frame(ok, got);
        exp_f = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp_f) begin
            errors++;
            $display("[TB] FAIL after_bad_chk_frame: got ok=%b %h, required %h", ok, got, exp_f);
        end
        release_frame();
    endtask

    task automatic test_len_limits();
        frame_t       exp_f, got;
        bit           ok;
        logic [127:0] pl;
        send_frame(8'h01, 16'h0000, 8'h11, '0, 1'b0, 1);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) pl[i*8 +: 8] = 8'($urandom_range(0, 255));
        send_frame(8'h5C, 16'h0F0F, 8'd16, pl, 1'b0, 1);
        collect_frame(ok, got);
        exp_f = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp_f) begin
            errors++;
            $display("[TB] FAIL max_len_frame: got ok=%b %h, required %h", ok, got, exp_f);
        end
        release_frame();
    endtask

    task automatic test_timeout();
        int  n;
        bit  seen;
        seen = 1'b0;
        n    = 0;
        exp_err.push_back(2'd1);
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        for (int i = 0; i < TO_CYC + 50; i++) begin
            if (err === 1'b1) begin
                seen = 1'b1;
                n    = i;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen || n < TO_CYC - 5 || n > TO_CYC + 5) begin
            errors++;
            $display("[TB] FAIL timeout_window: got seen=%b after %0d clk, required ~%0d",
                     seen, n, TO_CYC);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err_code !== 2'd1) begin
            errors++;
            $display("[TB] FAIL err_code_held: got %0d, required 1", err_code);
        end
    endtask

    task automatic test_long_rx_done();
        frame_t exp_f, got;
        bit     ok;
        send_frame(8'h20, 16'hA55A, 8'd1, 128'h77, 1'b0, 5000);
        collect_frame(ok, got);
        exp_f = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp_f) begin
            errors++;
            $display("[TB] FAIL long_rx_done_frame: got ok=%b %h, required %h", ok, got, exp_f);
        end
        release_frame();
    endtask

    task automatic test_overrun();
        frame_t exp_f, got;
        bit     ok;
        send_frame(8'h44, 16'h5566, 8'd2, 128'h2211, 1'b0, 1);
        collect_frame(ok, got);
        exp_f = exp_q.pop_front();
        exp_err.push_back(2'd3);
        send_byte(8'h5A, 1);
        collect_frame(ok, got);
        checks++;
        if (!ok || got !== exp_f) begin
            errors++;
            $display("[TB] FAIL overrun_frame_intact: got ok=%b %h, required %h", ok, got, exp_f);
        end
        release_frame();
    endtask

    task automatic test_back_to_back();
        frame_t exp_f, got;
        bit     ok;
        send_frame(8'h66, 16'h0102, 8'd1, 128'h99, 1'b0, 1);
        collect_frame(ok, got);
        exp_f = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp_f) begin
            errors++;
            $display("[TB] FAIL b2b_first_frame: got ok=%b %h, required %h", ok, got, exp_f);
        end
        exp_err.push_back(2'd3);
        rx_data   = 8'hA5;
        rx_done   = 1'b1;
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        rx_done   = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_with_byte: got valid=%b, required 0", cmd_valid);
        end
        @(negedge clk);
        send_frame(8'h67, 16'h0304, 8'd2, 128'hBBAA, 1'b0, 1);
        collect_frame(ok, got);
        exp_f = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp_f) begin
            errors++;
            $display("[TB] FAIL b2b_second_frame: got ok=%b %h, required %h", ok, got, exp_f);
        end
        release_frame();
    endtask

    task automatic test_reset_mid_payload();
        frame_t exp_f, got;
        bit     ok;
        send_byte(8'hA5, 1);
        send_byte(8'h10, 1);
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        send_byte(8'h04, 1);
        send_byte(8'hAB, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if ({cmd_valid, err, err_code, cmd_op, cmd_addr, cmd_len} !== 37'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_payload: got v=%b e=%b c=%0d op=%h a=%h l=%h, required all 0",
                     cmd_valid, err, err_code, cmd_op, cmd_addr, cmd_len);
        end
        @(negedge clk);
        send_frame(8'h7E, 16'hCAFE, 8'd4, 128'h04030201, 1'b0, 1);
        collect_frame(ok, got);
        exp_f = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp_f) begin
            errors++;
            $display("[TB] FAIL post_reset_frame: got ok=%b %h, required %h", ok, got, exp_f);
        end
        release_frame();
    endtask

    task automatic test_scoreboard_empty();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_err.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d errs %0d frames pending, required 0 0",
                     exp_err.size(), exp_q.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_len_zero();
        test_bad_checksum();
        test_len_limits();
        test_timeout();
        test_long_rx_done();
        test_overrun();
        test_back_to_back();
        test_reset_mid_payload();
        test_scoreboard_empty();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
